// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM control unit.
// Holds the state enum, ALU codes, mux-select codes and the multiply pattern.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    MULEX    = 4'd10,
    MULWB_LO = 4'd11,
    MULWB_HI = 4'd12
  } state_t;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_ORR   = 3'b011;
  localparam logic [2:0] ALU_MUL   = 3'b100;
  localparam logic [2:0] ALU_UMULL = 3'b101;
  localparam logic [2:0] ALU_SMULL = 3'b110;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_MUL    = 2'b11;

  localparam logic [1:0] SRCB_RM   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  localparam logic [3:0] MULOP_PATTERN = 4'b1001;

  function automatic logic is_mul(input logic [1:0] op, input logic [5:0] funct,
                                  input logic [3:0] mulop);
    return (op == 2'b00) && !funct[5] && (mulop == MULOP_PATTERN);
  endfunction

endpackage

// File: rtl/mc_decode_fsm_if.sv
// Instruction-field / control-word bundle between the IR+memory side and the FSM.
// mem_ready is a one-sided completion strobe: the FSM waits in a memory state until it is 1.
interface mc_decode_fsm_if #(parameter int ALUW = 3);
  logic [1:0]      Op;
  logic [5:0]      Funct;
  logic [3:0]      Rd;
  logic [3:0]      MulOp;
  logic            mem_ready;
  logic            IRWrite;
  logic            NextPC;
  logic            Branch;
  logic            PCS;
  logic            RegW;
  logic            MemW;
  logic            AdrSrc;
  logic            ALUSrcA;
  logic [1:0]      ALUSrcB;
  logic [1:0]      ResultSrc;
  logic [1:0]      ImmSrc;
  logic [1:0]      RegSrc;
  logic [ALUW-1:0] ALUControl;
  logic [1:0]      FlagW;
  logic            MulStart;
  logic            MulHi;

  modport master (
    output Op, Funct, Rd, MulOp, mem_ready,
    input  IRWrite, NextPC, Branch, PCS, RegW, MemW, AdrSrc, ALUSrcA, ALUSrcB,
           ResultSrc, ImmSrc, RegSrc, ALUControl, FlagW, MulStart, MulHi
  );

  modport slave (
    input  Op, Funct, Rd, MulOp, mem_ready,
    output IRWrite, NextPC, Branch, PCS, RegW, MemW, AdrSrc, ALUSrcA, ALUSrcB,
           ResultSrc, ImmSrc, RegSrc, ALUControl, FlagW, MulStart, MulHi
  );
endinterface

// File: rtl/mc_alu_decoder.sv
// Combinational ALU/multiply opcode and flag-write decode.
// op_valid is low for an unsupported data-processing command so the FSM can drop its writeback.
module mc_alu_decoder
  import mc_ctrl_pkg::*;
#(
  parameter int ALUW = 3
) (
  input  logic [4:0]      Funct,
  input  logic [3:0]      MulOp,
  input  logic            is_exec,
  output logic [ALUW-1:0] ALUControl,
  output logic [1:0]      FlagW,
  output logic            op_valid
);

  logic [2:0] code;

  always_comb begin
    code     = ALU_ADD;
    FlagW    = 2'b00;
    op_valid = 1'b0;
    if (is_exec) begin
      op_valid = 1'b1;
      case (Funct[4:1])
        4'b0100: code = ALU_ADD;
        4'b0010: code = ALU_SUB;
        4'b0000: code = ALU_AND;
        4'b1100: code = ALU_ORR;
        default: op_valid = 1'b0;
      endcase
      // C,V only make sense for arithmetic ops
      if (op_valid)
        FlagW = {Funct[0], Funct[0] & ((code == ALU_ADD) || (code == ALU_SUB))};
    end else if (MulOp == MULOP_PATTERN) begin
      op_valid = 1'b1;
      case (Funct[3:1])
        3'b100:  code = ALU_UMULL;
        3'b110:  code = ALU_SMULL;
        default: code = ALU_MUL;
      endcase
      FlagW = {Funct[0], 1'b0};
    end
  end

  assign ALUControl = ALUW'(code);

endmodule

// File: rtl/mc_decode_fsm.sv
// Multicycle ARM control FSM: one control word per cycle, stalls on mem_ready,
// iterative multiply with a MUL_LAT-cycle execute phase.
module mc_decode_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int ALUW    = 3,
  parameter int MUL_LAT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  mc_decode_fsm_if.slave       bus,
  output state_t               state
);

  localparam logic [3:0] MUL_INIT = 4'(MUL_LAT - 1);

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            is_exec;
  logic [ALUW-1:0] dec_alu;
  logic [1:0]      dec_flag;
  logic            dec_ok;

  assign state   = state_q;
  assign is_exec = (state_q == EXECR) || (state_q == EXECI) || (state_q == ALUWB);

  mc_alu_decoder #(.ALUW(ALUW)) u_alu_dec (
    .Funct      (bus.Funct[4:0]),
    .MulOp      (bus.MulOp),
    .is_exec    (is_exec),
    .ALUControl (dec_alu),
    .FlagW      (dec_flag),
    .op_valid   (dec_ok)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      FETCH:  if (bus.mem_ready) state_d = DECODE;
      DECODE: begin
        case (bus.Op)
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
          2'b00: begin
            if (is_mul(bus.Op, bus.Funct, bus.MulOp)) begin
              state_d = MULEX;
              cnt_d   = MUL_INIT;
            end else if (bus.Funct[5]) state_d = EXECI;
            else                       state_d = EXECR;
          end
          default: state_d = FETCH;
        endcase
      end
      MEMADR:   state_d = bus.Funct[0] ? MEMRD : MEMWR;
      MEMRD:    if (bus.mem_ready) state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWR:    if (bus.mem_ready) state_d = FETCH;
      EXECR:    state_d = ALUWB;
      EXECI:    state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BRANCH:   state_d = FETCH;
      MULEX: begin
        if (cnt_q == 4'd0) state_d = MULWB_LO;
        else               cnt_d   = cnt_q - 4'd1;
      end
      MULWB_LO: state_d = bus.Funct[3] ? MULWB_HI : FETCH;
      MULWB_HI: state_d = FETCH;
      default:  state_d = FETCH;
    endcase
  end

  // Outputs are forced low while reset is held, even though the state register sits in FETCH.
  always_comb begin
    bus.IRWrite    = 1'b0;
    bus.NextPC     = 1'b0;
    bus.Branch     = 1'b0;
    bus.PCS        = 1'b0;
    bus.RegW       = 1'b0;
    bus.MemW       = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.ALUSrcA    = 1'b0;
    bus.ALUSrcB    = SRCB_RM;
    bus.ResultSrc  = RES_ALUOUT;
    bus.ImmSrc     = IMM_DP;
    bus.RegSrc     = 2'b00;
    bus.ALUControl = ALUW'(ALU_ADD);
    bus.FlagW      = 2'b00;
    bus.MulStart   = 1'b0;
    bus.MulHi      = 1'b0;
    if (reset) begin
      case (bus.Op)
        2'b01:   begin bus.ImmSrc = IMM_MEM; bus.RegSrc = 2'b10; end
        2'b10:   begin bus.ImmSrc = IMM_BR;  bus.RegSrc = 2'b01; end
        default: begin bus.ImmSrc = IMM_DP;  bus.RegSrc = 2'b00; end
      endcase
      case (state_q)
        FETCH: begin
          bus.ALUSrcA   = 1'b1;
          bus.ALUSrcB   = SRCB_FOUR;
          bus.ResultSrc = RES_ALU;
          bus.IRWrite   = bus.mem_ready;
          bus.NextPC    = bus.mem_ready;
        end
        DECODE: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = SRCB_FOUR;
        end
        MEMADR: bus.ALUSrcB = SRCB_IMM;
        MEMRD:  bus.AdrSrc  = 1'b1;
        MEMWB: begin
          bus.RegW      = 1'b1;
          bus.ResultSrc = RES_RDATA;
          bus.PCS       = (bus.Rd == 4'd15);
        end
        MEMWR: begin
          bus.AdrSrc = 1'b1;
          bus.MemW   = bus.mem_ready;
        end
        EXECR, EXECI: begin
          bus.ALUSrcB    = (state_q == EXECI) ? SRCB_IMM : SRCB_RM;
          bus.ALUControl = dec_alu;
          bus.FlagW      = dec_flag;
        end
        ALUWB: begin
          bus.RegW      = dec_ok;
          bus.ResultSrc = RES_ALUOUT;
          bus.PCS       = dec_ok && (bus.Rd == 4'd15);
        end
        BRANCH: begin
          bus.ALUSrcB   = SRCB_IMM;
          bus.ResultSrc = RES_ALU;
          bus.Branch    = 1'b1;
        end
        MULEX: begin
          bus.ALUControl = dec_alu;
          bus.MulStart   = (cnt_q == MUL_INIT);
        end
        MULWB_LO: begin
          bus.RegW       = 1'b1;
          bus.ResultSrc  = RES_MUL;
          bus.ALUControl = dec_alu;
          bus.FlagW      = dec_flag;
        end
        MULWB_HI: begin
          bus.RegW       = 1'b1;
          bus.ResultSrc  = RES_MUL;
          bus.ALUControl = dec_alu;
          bus.MulHi      = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_decode_fsm.sv
// Directed bench for mc_decode_fsm: two instances (MUL_LAT=4 and MUL_LAT=1) share clock and reset.
module tb_mc_decode_fsm;
  import mc_ctrl_pkg::*;

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  state_t st4, st1;
  int     n_chk = 0;
  int     n_fail = 0;

  mc_decode_fsm_if #(.ALUW(3)) bus4 ();
  mc_decode_fsm_if #(.ALUW(3)) bus1 ();

  mc_decode_fsm #(.ALUW(3), .MUL_LAT(4)) u4 (.clk(clk), .reset(reset), .bus(bus4), .state(st4));
  mc_decode_fsm #(.ALUW(3), .MUL_LAT(1)) u1 (.clk(clk), .reset(reset), .bus(bus1), .state(st1));

  logic [22:0] ctl4;
  assign ctl4 = {bus4.IRWrite, bus4.NextPC, bus4.Branch, bus4.PCS, bus4.RegW, bus4.MemW,
                 bus4.AdrSrc, bus4.ALUSrcA, bus4.ALUSrcB, bus4.ResultSrc, bus4.ImmSrc,
                 bus4.RegSrc, bus4.ALUControl, bus4.FlagW, bus4.MulStart, bus4.MulHi};

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd,
                       input logic [3:0] mulop, input logic mr);
    bus4.Op = op; bus4.Funct = funct; bus4.Rd = rd; bus4.MulOp = mulop; bus4.mem_ready = mr;
    bus1.Op = op; bus1.Funct = funct; bus1.Rd = rd; bus1.MulOp = mulop; bus1.mem_ready = mr;
  endtask

  task automatic set_mr(input logic mr);
    bus4.mem_ready = mr;
    bus1.mem_ready = mr;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    drive(2'b00, 6'b0, 4'd0, 4'd0, 1'b0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
  endtask

  initial begin
    drive(2'b00, 6'b0, 4'd0, 4'd0, 1'b0);
    #1 reset = 1'b0;
    #1;
    chk("rst_state", st4, FETCH);
    chk("rst_ctl", ctl4, 0);
    tick();
    chk("rst_hold_state", st4, FETCH);
    chk("rst_hold_ctl", ctl4, 0);
    reset = 1'b1;

    // ADDS R1,R2,R3 with one stalled fetch cycle first
    drive(2'b00, 6'b001001, 4'd1, 4'd0, 1'b0);
    #1;
    chk("fetch_stall_irw", bus4.IRWrite, 0);
    chk("fetch_stall_npc", bus4.NextPC, 0);
    chk("fetch_srca", bus4.ALUSrcA, 1);
    chk("fetch_srcb", bus4.ALUSrcB, 2'b10);
    chk("fetch_res", bus4.ResultSrc, 2'b10);
    tick();
    chk("fetch_stall_state", st4, FETCH);
    set_mr(1'b1);
    chk("fetch_irw", bus4.IRWrite, 1);
    chk("fetch_npc", bus4.NextPC, 1);
    tick();
    chk("adds_decode", st4, DECODE);
    chk("decode_srcb", bus4.ALUSrcB, 2'b10);
    tick();
    chk("adds_execr", st4, EXECR);
    chk("adds_alu", bus4.ALUControl, 3'b000);
    chk("adds_flagw", bus4.FlagW, 2'b11);
    tick();
    chk("adds_aluwb", st4, ALUWB);
    chk("adds_regw", bus4.RegW, 1);
    chk("adds_res", bus4.ResultSrc, 2'b00);
    chk("adds_pcs", bus4.PCS, 0);
    tick();
    chk("adds_back_fetch", st4, FETCH);

    // LDR with memory stalled three cycles
    drive(2'b01, 6'b011001, 4'd2, 4'd0, 1'b1);
    tick();
    tick();
    chk("ldr_memadr", st4, MEMADR);
    chk("ldr_srcb", bus4.ALUSrcB, 2'b01);
    chk("ldr_immsrc", bus4.ImmSrc, 2'b01);
    chk("ldr_regsrc", bus4.RegSrc, 2'b10);
    set_mr(1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ldr_memrd_wait", st4, MEMRD);
      chk("ldr_adrsrc", bus4.AdrSrc, 1);
      chk("ldr_no_regw", bus4.RegW, 0);
    end
    set_mr(1'b1);
    chk("ldr_memrd_last", st4, MEMRD);
    tick();
    chk("ldr_memwb", st4, MEMWB);
    chk("ldr_regw", bus4.RegW, 1);
    chk("ldr_res", bus4.ResultSrc, 2'b01);
    tick();
    chk("ldr_back_fetch", st4, FETCH);

    // STR: MemW only while mem_ready is high
    drive(2'b01, 6'b011000, 4'd3, 4'd0, 1'b1);
    tick();
    tick();
    set_mr(1'b0);
    tick();
    chk("str_memwr", st4, MEMWR);
    chk("str_memw_wait", bus4.MemW, 0);
    chk("str_adrsrc", bus4.AdrSrc, 1);
    set_mr(1'b1);
    chk("str_memw", bus4.MemW, 1);
    tick();
    chk("str_back_fetch", st4, FETCH);
    chk("str_memw_done", bus4.MemW, 0);

    // undefined Op=11
    drive(2'b11, 6'b000000, 4'd0, 4'd0, 1'b1);
    tick();
    chk("op11_decode", st4, DECODE);
    chk("op11_regw", bus4.RegW, 0);
    chk("op11_memw", bus4.MemW, 0);
    tick();
    chk("op11_fetch", st4, FETCH);
    chk("op11_fetch_regw", bus4.RegW, 0);

    // SUBS immediate
    drive(2'b00, 6'b100101, 4'd4, 4'd0, 1'b1);
    tick();
    tick();
    chk("subs_execi", st4, EXECI);
    chk("subs_alu", bus4.ALUControl, 3'b001);
    chk("subs_flagw", bus4.FlagW, 2'b11);
    chk("subs_srcb", bus4.ALUSrcB, 2'b01);
    tick();
    chk("subs_regw", bus4.RegW, 1);
    tick();

    // ORRS to PC
    drive(2'b00, 6'b011001, 4'd15, 4'd0, 1'b1);
    tick();
    tick();
    chk("orrs_alu", bus4.ALUControl, 3'b011);
    chk("orrs_flagw", bus4.FlagW, 2'b10);
    tick();
    chk("orrs_regw", bus4.RegW, 1);
    chk("orrs_pcs", bus4.PCS, 1);
    tick();

    // unsupported command with S set: no flags, no writeback
    drive(2'b00, 6'b011111, 4'd5, 4'd0, 1'b1);
    tick();
    tick();
    chk("undef_alu", bus4.ALUControl, 3'b000);
    chk("undef_flagw", bus4.FlagW, 2'b00);
    tick();
    chk("undef_aluwb", st4, ALUWB);
    chk("undef_regw", bus4.RegW, 0);
    tick();

    // branch
    drive(2'b10, 6'b100000, 4'd0, 4'd0, 1'b1);
    tick();
    tick();
    chk("b_state", st4, BRANCH);
    chk("b_branch", bus4.Branch, 1);
    chk("b_immsrc", bus4.ImmSrc, 2'b10);
    chk("b_srcb", bus4.ALUSrcB, 2'b01);
    chk("b_regsrc", bus4.RegSrc, 2'b01);
    tick();
    chk("b_back_fetch", st4, FETCH);

    // UMULLS on the MUL_LAT=4 instance
    drive(2'b00, 6'b001001, 4'd6, 4'b1001, 1'b1);
    tick();
    tick();
    chk("umull_mulex", st4, MULEX);
    chk("umull_start", bus4.MulStart, 1);
    chk("umull_alu", bus4.ALUControl, 3'b101);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("umull_mulex_hold", st4, MULEX);
      chk("umull_no_restart", bus4.MulStart, 0);
    end
    tick();
    chk("umull_wblo", st4, MULWB_LO);
    chk("umull_lo_flagw", bus4.FlagW, 2'b10);
    chk("umull_lo_hi", bus4.MulHi, 0);
    chk("umull_lo_regw", bus4.RegW, 1);
    chk("umull_lo_res", bus4.ResultSrc, 2'b11);
    tick();
    chk("umull_wbhi", st4, MULWB_HI);
    chk("umull_hi_hi", bus4.MulHi, 1);
    chk("umull_hi_flagw", bus4.FlagW, 2'b00);
    chk("umull_hi_regw", bus4.RegW, 1);
    tick();
    chk("umull_back_fetch", st4, FETCH);

    // MUL on the MUL_LAT=1 instance
    do_reset();
    drive(2'b00, 6'b000000, 4'd7, 4'b1001, 1'b1);
    tick();
    chk("mul1_decode", st1, DECODE);
    tick();
    chk("mul1_mulex", st1, MULEX);
    chk("mul1_start", bus1.MulStart, 1);
    chk("mul1_alu", bus1.ALUControl, 3'b100);
    tick();
    chk("mul1_wblo", st1, MULWB_LO);
    chk("mul1_flagw", bus1.FlagW, 2'b00);
    chk("mul1_hi", bus1.MulHi, 0);
    tick();
    chk("mul1_no_wbhi", st1, FETCH);

    // reset in the middle of MULEX
    do_reset();
    drive(2'b00, 6'b001000, 4'd8, 4'b1001, 1'b1);
    tick();
    tick();
    chk("rstmul_start", bus4.MulStart, 1);
    tick();
    chk("rstmul_mulex2", st4, MULEX);
    reset = 1'b0;
    #1;
    chk("rstmul_async_state", st4, FETCH);
    chk("rstmul_async_ctl", ctl4, 0);
    tick();
    chk("rstmul_hold_state", st4, FETCH);
    chk("rstmul_hold_ctl", ctl4, 0);
    set_mr(1'b0);
    reset = 1'b1;
    #1;
    chk("rstmul_rel_start", bus4.MulStart, 0);
    tick();
    chk("rstmul_rel_state", st4, FETCH);
    chk("rstmul_rel_start2", bus4.MulStart, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
